// File: rtl/vblank_scheduler.sv
// vblank_scheduler: grants the blanking-window update slot to one object at a time.
// The window opens on the rising edge of animate and closes on the rising edge of blank_end.
// Requesters are served round-robin from a start index that rotates every frame.
// Each grant ends on done, on a MAX_GRANT-cycle timeout, or when the window closes.
module vblank_scheduler #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned MAX_GRANT = 1024
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             animate_i,
    input  logic             blank_end_i,
    input  logic [N_REQ-1:0] req_i,
    input  logic [N_REQ-1:0] done_i,
    output logic [N_REQ-1:0] grant_o,
    output logic             busy_o,
    output logic             window_done_o,
    output logic             overrun_o,
    output logic [N_REQ-1:0] timeout_o,
    output logic [15:0]      frame_cnt_o
);

    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned TW = (MAX_GRANT > 1) ? $clog2(MAX_GRANT) : 1;
    localparam logic [TW-1:0] TimerLast = TW'(MAX_GRANT - 1);
    localparam logic [IW-1:0] IdxLast   = IW'(N_REQ - 1);

    typedef enum logic [1:0] {StIdle, StScan, StGrant} state_e;

    state_e           state_q, state_d;
    logic             animate_q, blank_end_q;
    logic [N_REQ-1:0] served_q, served_d;
    logic [N_REQ-1:0] timeout_q, timeout_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]    base_q, base_d;
    logic [IW-1:0]    g_q, g_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             window_done_q, window_done_d;
    logic             overrun_q, overrun_d;

    logic             open, close;
    logic [N_REQ-1:0] eligible;
    logic             found;
    logic [IW-1:0]    pick_idx;

    assign open  = animate_i & ~animate_q;
    assign close = blank_end_i & ~blank_end_q;

    // Round-robin search for the first unserved requester, starting at this frame's base.
    always_comb begin : pick
        int unsigned idx;
        idx      = 0;
        eligible = req_i & ~served_q;
        found    = 1'b0;
        pick_idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = i + 32'(base_q);
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && eligible[idx]) begin
                found    = 1'b1;
                pick_idx = IW'(idx);
            end
        end
    end

    // Next-state and registered-output logic; close outranks every other transition.
    always_comb begin
        state_d       = state_q;
        served_d      = served_q;
        timeout_d     = timeout_q;
        frame_cnt_d   = frame_cnt_q;
        rr_ptr_d      = rr_ptr_q;
        base_d        = base_q;
        g_d           = g_q;
        timer_d       = timer_q;
        grant_d       = '0;
        window_done_d = 1'b0;
        overrun_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (open) begin
                    served_d    = '0;
                    timeout_d   = '0;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    base_d      = rr_ptr_q;
                    rr_ptr_d    = (rr_ptr_q == IdxLast) ? '0 : rr_ptr_q + IW'(1);
                    state_d     = StScan;
                end
            end
            StScan: begin
                if (close) begin
                    overrun_d = 1'b1;
                    state_d   = StIdle;
                end else if (found) begin
                    g_d               = pick_idx;
                    timer_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    state_d           = StGrant;
                end else begin
                    window_done_d = 1'b1;
                    state_d       = StIdle;
                end
            end
            StGrant: begin
                if (close) begin
                    overrun_d = 1'b1;
                    state_d   = StIdle;
                end else if (done_i[g_q]) begin
                    served_d[g_q] = 1'b1;
                    state_d       = StScan;
                end else if (timer_q == TimerLast) begin
                    served_d[g_q]  = 1'b1;
                    timeout_d[g_q] = 1'b1;
                    state_d        = StScan;
                end else begin
                    timer_d       = timer_q + TW'(1);
                    grant_d[g_q]  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers; animate_q resets high so a level already high at
    // reset release is not taken as an edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            animate_q     <= 1'b1;
            blank_end_q   <= 1'b0;
            served_q      <= '0;
            timeout_q     <= '0;
            grant_q       <= '0;
            frame_cnt_q   <= '0;
            rr_ptr_q      <= '0;
            base_q        <= '0;
            g_q           <= '0;
            timer_q       <= '0;
            window_done_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            animate_q     <= animate_i;
            blank_end_q   <= blank_end_i;
            served_q      <= served_d;
            timeout_q     <= timeout_d;
            grant_q       <= grant_d;
            frame_cnt_q   <= frame_cnt_d;
            rr_ptr_q      <= rr_ptr_d;
            base_q        <= base_d;
            g_q           <= g_d;
            timer_q       <= timer_d;
            window_done_q <= window_done_d;
            overrun_q     <= overrun_d;
        end
    end

    assign grant_o       = grant_q;
    assign busy_o        = (state_q != StIdle);
    assign window_done_o = window_done_q;
    assign overrun_o     = overrun_q;
    assign timeout_o     = timeout_q;
    assign frame_cnt_o   = frame_cnt_q;

endmodule
